// File: rtl/i2c_timer_pkg.sv
// Shared types and constants for the I2C phase timer family.
package i2c_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam int DEF_SIZE   = 8;
  localparam int DEF_PHASES = 4;

  // Phase indices of the standard 4-phase I2C bit.
  localparam int PH_SCL_LO   = 0;
  localparam int PH_SCL_RISE = 1;
  localparam int PH_SCL_HI   = 2;
  localparam int PH_SCL_FALL = 3;

endpackage

// File: rtl/i2c_phase_counter.sv
// Loadable down-counter that stops at zero; one instance times each phase.
module i2c_phase_counter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            hold,
  input  logic [SIZE-1:0] load_val,
  output logic [SIZE-1:0] count,
  output logic            zero
);

  // Load has priority; otherwise count down while enabled and non-zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - SIZE'(1);
    end
  end

  // Terminal flag for the controlling FSM.
  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/i2c_phase_timer.sv
// Multi-phase I2C bit timer: phase strobes, bit-done strobe, SCL stretch hold.
module i2c_phase_timer
  import i2c_timer_pkg::*;
#(
  parameter  int SIZE          = DEF_SIZE,
  parameter  int PHASES        = DEF_PHASES,
  parameter  int STRETCH_PHASE = PH_SCL_RISE,
  localparam int PW            = $clog2(PHASES)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Continuous,
  input  logic                   Stretch,
  input  logic [PHASES*SIZE-1:0] Ticks,
  output logic                   Tick,
  output logic                   BitDone,
  output logic [PW-1:0]          Phase,
  output logic                   Busy,
  output logic                   Held
);

  timer_state_t    state;
  logic [SIZE-1:0] cnt;
  logic            cnt_zero;
  logic            cnt_load;
  logic [SIZE-1:0] cnt_val;
  logic            last_phase;
  logic [PW-1:0]   next_phase;
  logic            stretch_end;
  logic            advance;

  i2c_phase_counter #(.SIZE(SIZE)) u_counter (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (cnt_load),
    .hold     (state != RUN),
    .load_val (cnt_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Phase-boundary decode and counter reload selection.
  // The counter is reloaded on the same edge the FSM advances, so the
  // next phase's Ticks field is picked here from the upcoming index.
  always_comb begin
    last_phase  = (Phase == PW'(PHASES - 1));
    next_phase  = last_phase ? PW'(PH_SCL_LO) : Phase + PW'(1);
    stretch_end = (Phase == PW'(STRETCH_PHASE)) && Stretch;
    advance     = 1'b0;
    if (!Start && !Stop) begin
      case (state)
        RUN:     advance = cnt_zero && !stretch_end;
        HOLD:    advance = !Stretch;
        default: advance = 1'b0;
      endcase
    end
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (Start) begin
      cnt_load = 1'b1;
      cnt_val  = Ticks[SIZE-1:0];
    end else if (Stop) begin
      cnt_load = 1'b1;
    end else if (advance && !(last_phase && !Continuous)) begin
      cnt_load = 1'b1;
      cnt_val  = Ticks[next_phase*SIZE +: SIZE];
    end
  end

  // Control FSM with registered strobes and status.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      Phase   <= '0;
      Tick    <= 1'b0;
      BitDone <= 1'b0;
      Busy    <= 1'b0;
      Held    <= 1'b0;
    end else begin
      Tick    <= 1'b0;
      BitDone <= 1'b0;
      if (Start) begin
        state <= RUN;
        Phase <= PW'(PH_SCL_LO);
        Busy  <= 1'b1;
        Held  <= 1'b0;
      end else if (Stop) begin
        if (state != IDLE) begin
          state <= IDLE;
          Phase <= '0;
          Busy  <= 1'b0;
          Held  <= 1'b0;
        end
      end else if (state == RUN && cnt_zero && stretch_end) begin
        state <= HOLD;
        Held  <= 1'b1;
      end else if (advance) begin
        Tick  <= 1'b1;
        Held  <= 1'b0;
        Phase <= next_phase;
        if (last_phase) begin
          BitDone <= 1'b1;
          if (Continuous) begin
            state <= RUN;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Self-checking bench for i2c_phase_timer: per-cycle model compare plus literal edge checks.
module tb_i2c_phase_timer;

  localparam int SIZE          = 8;
  localparam int PHASES        = 4;
  localparam int STRETCH_PHASE = 1;
  localparam int PW            = 2;

  logic                   Clk = 1'b0;
  logic                   Rst_n = 1'b0;
  logic                   Start = 1'b0;
  logic                   Stop = 1'b0;
  logic                   Continuous = 1'b0;
  logic                   Stretch = 1'b0;
  logic [PHASES*SIZE-1:0] Ticks = '0;
  logic                   Tick;
  logic                   BitDone;
  logic [PW-1:0]          Phase;
  logic                   Busy;
  logic                   Held;

  i2c_phase_timer #(
    .SIZE          (SIZE),
    .PHASES        (PHASES),
    .STRETCH_PHASE (STRETCH_PHASE)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Stop       (Stop),
    .Continuous (Continuous),
    .Stretch    (Stretch),
    .Ticks      (Ticks),
    .Tick       (Tick),
    .BitDone    (BitDone),
    .Phase      (Phase),
    .Busy       (Busy),
    .Held       (Held)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each phase lasts Ticks_p+1 cycles counted upward from load.
  bit m_active, m_held, m_tick, m_bd;
  int m_phase, m_elapsed, m_len;

  function automatic int ticks_of(input int p);
    return int'(Ticks[p*SIZE +: SIZE]);
  endfunction

  task automatic m_end_phase();
    m_tick = 1;
    m_held = 0;
    if (m_phase == PHASES - 1) begin
      m_bd    = 1;
      m_phase = 0;
      if (Continuous) begin
        m_len     = ticks_of(0) + 1;
        m_elapsed = 0;
      end else begin
        m_active = 0;
      end
    end else begin
      m_phase   = m_phase + 1;
      m_len     = ticks_of(m_phase) + 1;
      m_elapsed = 0;
    end
  endtask

  task automatic m_step();
    m_tick = 0;
    m_bd   = 0;
    if (!Rst_n) begin
      m_active = 0; m_held = 0; m_phase = 0; m_elapsed = 0; m_len = 0;
    end else if (Start) begin
      m_active = 1; m_held = 0; m_phase = 0;
      m_len = ticks_of(0) + 1; m_elapsed = 0;
    end else if (Stop) begin
      m_active = 0; m_held = 0; m_phase = 0;
    end else if (m_active) begin
      if (m_held) begin
        if (!Stretch) m_end_phase();
      end else begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == m_len) begin
          if (m_phase == STRETCH_PHASE && Stretch) m_held = 1;
          else m_end_phase();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge Clk);
    m_step();
  end

  bit cmp_en = 0;

  initial forever begin
    @(negedge Clk);
    if (cmp_en) begin
      check("tick",    int'(Tick),    int'(m_tick));
      check("bitdone", int'(BitDone), int'(m_bd));
      check("phase",   int'(Phase),   m_phase);
      check("busy",    int'(Busy),    int'(m_active));
      check("held",    int'(Held),    int'(m_held));
    end
  end

  // Edge logging relative to the most recent Start edge (edge 0).
  int rel;
  int tick_q[$];
  int bd_q[$];
  int held_n;
  int want[$];

  task automatic cyc();
    @(posedge Clk);
    rel++;
    @(negedge Clk);
    if (Tick)    tick_q.push_back(rel);
    if (BitDone) bd_q.push_back(rel);
    if (Held)    held_n++;
  endtask

  task automatic start_bit();
    Start = 1'b1;
    rel = -1;
    tick_q.delete();
    bd_q.delete();
    held_n = 0;
    cyc();
    Start = 1'b0;
  endtask

  task automatic expect_q(input string name, input int q[$], input int e[$]);
    check({name, "_count"}, q.size(), e.size());
    foreach (e[i]) check(name, (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  initial begin
    // Reset
    Rst_n = 1'b0;
    repeat (2) cyc();
    cmp_en = 1;
    check("reset_busy", int'(Busy), 0);
    check("reset_phase", int'(Phase), 0);
    check("reset_tick", int'(Tick), 0);
    Rst_n = 1'b1;
    cyc();

    // One-shot, Ticks 1,2,0,3
    Ticks = 32'h03_00_02_01;
    Continuous = 1'b0;
    start_bit();
    repeat (12) cyc();
    want = {2, 5, 6, 10};
    expect_q("oneshot_ticks", tick_q, want);
    want = {10};
    expect_q("oneshot_bitdone", bd_q, want);
    check("oneshot_busy_end", int'(Busy), 0);

    // Continuous, three bits
    Continuous = 1'b1;
    start_bit();
    repeat (30) cyc();
    want = {10, 20, 30};
    expect_q("cont_bitdone", bd_q, want);
    check("cont_tick_count", tick_q.size(), 12);
    check("cont_busy", int'(Busy), 1);
    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
    check("cont_stop_busy", int'(Busy), 0);
    Continuous = 1'b0;
    cyc();

    // Stretch held over edges 5..9 at the end of phase 1
    start_bit();
    repeat (3) cyc();
    Stretch = 1'b1;
    repeat (6) cyc();
    Stretch = 1'b0;
    repeat (8) cyc();
    want = {2, 10, 11, 15};
    expect_q("stretch_ticks", tick_q, want);
    check("stretch_held_cycles", held_n, 5);

    // Stretch in phases 0 and 2 has no effect
    Stretch = 1'b1;
    start_bit();
    repeat (2) cyc();
    Stretch = 1'b0;
    repeat (3) cyc();
    Stretch = 1'b1;
    cyc();
    Stretch = 1'b0;
    repeat (6) cyc();
    want = {2, 5, 6, 10};
    expect_q("nostretch_ticks", tick_q, want);
    check("nostretch_held", held_n, 0);

    // Stop at edge 3, mid phase 1
    start_bit();
    repeat (2) cyc();
    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
    check("stop_busy", int'(Busy), 0);
    check("stop_phase", int'(Phase), 0);
    repeat (10) cyc();
    want = {2};
    expect_q("stop_ticks", tick_q, want);

    // Start together with Stop restarts at phase 0
    start_bit();
    repeat (3) cyc();
    Stop = 1'b1;
    start_bit();
    Stop = 1'b0;
    check("startstop_busy", int'(Busy), 1);
    check("startstop_phase", int'(Phase), 0);
    repeat (11) cyc();
    want = {2, 5, 6, 10};
    expect_q("startstop_ticks", tick_q, want);

    // Reset while in HOLD
    Stretch = 1'b1;
    start_bit();
    repeat (6) cyc();
    check("hold_held", int'(Held), 1);
    Rst_n = 1'b0;
    cyc();
    check("hold_rst_busy", int'(Busy), 0);
    check("hold_rst_held", int'(Held), 0);
    check("hold_rst_phase", int'(Phase), 0);
    check("hold_rst_tick", int'(Tick), 0);
    Rst_n = 1'b1;
    Stretch = 1'b0;
    cyc();

    // Reset pulse between edges is not seen
    start_bit();
    cyc();
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
    cyc();
    check("glitch_busy", int'(Busy), 1);
    check("glitch_tick", int'(Tick), 1);
    repeat (10) cyc();

    // All-zero Ticks, continuous
    Ticks = '0;
    Continuous = 1'b1;
    start_bit();
    repeat (12) cyc();
    check("zero_tick_count", tick_q.size(), 12);
    want = {4, 8, 12};
    expect_q("zero_bitdone", bd_q, want);
    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
    Continuous = 1'b0;

    // Maximum count on phase 0
    Ticks = 32'h00_00_00_FF;
    start_bit();
    repeat (262) cyc();
    want = {256, 257, 258, 259};
    expect_q("max_ticks", tick_q, want);
    want = {259};
    expect_q("max_bitdone", bd_q, want);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_phase_timer.md
Name: i2c_phase_timer

Overview:
Multi-phase, parametrised successor to the I2C single-period bit timer. Divides each I2C bit into PHASES programmable sub-intervals: SCL low, SDA setup, SCL high, hold, and so on. Emits a strobe at every phase boundary and a bit-done strobe at the end of the last phase. Supports one-shot or continuous operation and SCL clock-stretch holding. Feeds the I2C master bit-level FSM.

Parameters:
SIZE, 8, width of each per-phase tick count.
PHASES, 4, number of phases per bit; legal range 2..16.
STRETCH_PHASE, 1, index of the phase whose end may be held by Stretch.
PW, $clog2(PHASES), phase index width; derived localparam, not overridable.

Ports:
Clk  in  1  system clock, rising edge.
Rst_n  in  1  synchronous active-low reset.
Start  in  1  start or restart at phase 0.
Stop  in  1  abort and return to idle.
Continuous  in  1  1 = wrap after last phase; 0 = one-shot.
Stretch  in  1  1 = hold at the end of STRETCH_PHASE (SCL not yet high).
Ticks  in  PHASES*SIZE  phase p count at [p*SIZE +: SIZE]; phase lasts Ticks_p+1 cycles.
Tick  out  1  one-cycle strobe, phase boundary.
BitDone  out  1  one-cycle strobe, end of phase PHASES-1.
Phase  out  PW  current phase index.
Busy  out  1  timer running or held.
Held  out  1  currently held by Stretch.

Behaviour:
- Reset is synchronous: Rst_n=0 sampled at a Clk edge forces IDLE, cnt=0, Phase=0, and Tick=BitDone=Busy=Held=0. Reset has the highest priority.
- All outputs are registered. States are IDLE, RUN and HOLD.
- Per-edge priority: Rst_n, then Start, then Stop, then the terminal/hold check, then decrement.
- Start (any state): Phase<=0, cnt<=Ticks_0, Busy<=1, Held<=0, state RUN. No Tick is produced on Start. Start while running discards the current bit.
- Stop (not Start): state IDLE, Phase<=0, cnt<=0, Busy<=0, Held<=0, no strobes. Stop in IDLE has no effect.
- RUN with cnt!=0: cnt<=cnt-1.
- RUN with cnt==0 at the end of phase p:
  - If p==STRETCH_PHASE and Stretch=1: go to HOLD, Held<=1, no Tick.
  - Otherwise Tick<=1 and the phase advances:
    - p<PHASES-1: Phase<=p+1, cnt<=Ticks_(p+1).
    - p==PHASES-1: BitDone<=1 as well.
      - Continuous=1: Phase<=0, cnt<=Ticks_0.
      - Continuous=0: state IDLE, Busy<=0, Phase<=0.
- HOLD: cnt stays at 0. On the first edge where Stretch is sampled 0, Held<=0, Tick<=1, and the phase advances as above. HOLD extends the phase by the number of cycles Stretch stays high. Stretch has no effect in any other phase.
- Ticks_p is sampled only when phase p is loaded, so software may reprogram later phases mid-bit.
- Ticks_p=0 gives a 1-cycle phase. All-zero Ticks in continuous mode gives Tick high every cycle and BitDone every PHASES cycles.
- Tick and BitDone are high for exactly the one cycle after the terminal edge, aligned with the new Phase value.
- Counter arithmetic is unsigned SIZE bits. The decrement never wraps because the reload happens at 0.
- Start and Stop asserted together: Start wins.
- Reset during HOLD or RUN goes straight to IDLE with no strobes.

Decomposition:
- Shared package i2c_timer_pkg holds:
  - the state encoding localparams IDLE=2'd0, RUN=2'd1, HOLD=2'd2;
  - the default SIZE and PHASES;
  - the named phase indices for the standard 4-phase bit: PH_SCL_LO=0, PH_SCL_RISE=1, PH_SCL_HI=2, PH_SCL_FALL=3.
- One natural sub-module, i2c_phase_counter: SIZE-bit loadable down-counter with Load, Hold and Zero flag. The top level keeps the FSM, phase indexing and Ticks muxing.

Test Plan:
- Ticks p0..p3 = 1,2,0,3, Continuous=0, Start at edge 0 -> Tick at edges 2,5,6,10. Phase reads 1,2,3,0 after those edges. BitDone with the 4th Tick. Busy falls at edge 10.
- Same setup with Continuous=1, run 3 bits -> BitDone every 10 cycles, Phase wraps 3->0, Busy stays 1.
- Stretch=1 held for 5 cycles at the end of phase 1 -> Held=1 for 5 cycles and the phase 1 Tick is delayed by 5. Later Ticks shift by 5. Stretch pulsed during phase 0 or 2 -> no effect.
- Stop at edge 3 mid-phase 1 -> Busy=0, Phase=0 next cycle, no further Tick. Start together with Stop -> restarts at phase 0.
- Rst_n=0 for one edge while in HOLD -> all outputs 0 next cycle. Reset asserted between edges -> no change until the next edge (synchronous).
- All Ticks=0, Continuous=1 -> Tick every cycle, BitDone every 4th. Ticks=255 on phase 0 -> first Tick 256 cycles after Start.
